gb_cpu_fetch: RTL and testbench

Instruction fetch front end for the Game Boy CPU core. Reads opcode bytes from the memory bus at the program counter, folds a `0xCB` prefix byte into a `cb_prefix` flag, and presents the resulting `opcode`/`cb_prefix` pair to `gb_cpu_decoder` and the sequencer through a valid/ready handshake. Owns the PC for opcode fetch. The sequencer advances the PC for immediate operands and redirects it on jumps, calls, returns and interrupts.

---
 rtl/gb_cpu_fetch.sv | 101 ++++++++++
 tb/tb_gb_cpu_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_cpu_fetch.sv
// gb_cpu_fetch: opcode fetch front end for the Game Boy CPU core.
// Fetches one byte per opcode (two for 0xCB-prefixed ones), presents the
// opcode/cb_prefix pair through a valid/ready handshake and owns the PC.
module gb_cpu_fetch #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  opcode,
  output logic        cb_prefix,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [15:0] pc,
  input  logic        pc_adv,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_CB_FETCH,
    S_CB_WAIT,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  opcode_q, opcode_d;
  logic        cb_q, cb_d;

  // State, PC and opcode registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_RESET;
      opcode_q <= 8'h00;
      cb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      cb_q     <= cb_d;
    end
  end

  // Next-state logic; redirect overrides everything, including an accept
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    cb_d     = cb_q;
    case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        pc_d = pc_q + 16'd1;
        if (mem_rdata == 8'hCB) begin
          state_d = S_CB_FETCH;
        end else begin
          opcode_d = mem_rdata;
          cb_d     = 1'b0;
          state_d  = S_HOLD;
        end
      end
      S_CB_FETCH: state_d = S_CB_WAIT;
      S_CB_WAIT: begin
        // A second 0xCB is just an ordinary CB-table opcode; no chaining.
        pc_d     = pc_q + 16'd1;
        opcode_d = mem_rdata;
        cb_d     = 1'b1;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (pc_adv) pc_d = pc_q + 16'd1;
        if (op_ready) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (redirect) begin
      // Drop any in-flight byte: keep the previously presented opcode.
      pc_d     = redirect_pc;
      state_d  = S_FETCH;
      opcode_d = opcode_q;
      cb_d     = cb_q;
    end
  end

  // Outputs are decoded from state or taken straight from registers
  always_comb begin
    mem_rd    = (state_q == S_FETCH) || (state_q == S_CB_FETCH);
    mem_addr  = pc_q;
    op_valid  = (state_q == S_HOLD);
    opcode    = opcode_q;
    cb_prefix = cb_q;
    pc        = pc_q;
  end

endmodule

// File: tb/tb_gb_cpu_fetch.sv
// Testbench for gb_cpu_fetch: byte-wide memory model with one-cycle read
// latency, scoreboard of expected opcodes, one task per scenario.
module tb_gb_cpu_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic [7:0]  opcode;
  logic        cb_prefix;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] pc;
  logic        pc_adv;
  logic        redirect;
  logic [15:0] redirect_pc;

  typedef struct {
    logic [7:0]  op;
    logic        cb;
    logic [15:0] pcv;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [7:0] mem [0:65535];
  int n_vec = 0;
  int n_err = 0;

  gb_cpu_fetch #(.PC_RESET(16'h0100)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .opcode(opcode), .cb_prefix(cb_prefix),
    .op_valid(op_valid), .op_ready(op_ready), .pc(pc), .pc_adv(pc_adv),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory returns the addressed byte in the cycle after the read strobe
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Waits (bounded) on negedges until op_valid; cyc counts cycles waited
  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (op_valid !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Redirect pulse driven at a negedge; returns at cycle 0 of the new fetch
  task automatic redirect_to(input logic [15:0] a);
    redirect = 1'b1;
    redirect_pc = a;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  // Pops the oldest expectation and compares it with the presented opcode
  task automatic pop_compare(input string name, input int cyc);
    n_vec++;
    if (op_valid !== 1'b1 || sb.size() == 0) begin
      n_err++;
      $display("FAIL %s timeout: op_valid=%b queued=%0d, required op_valid=1", name, op_valid, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      $display("%s: opcode=%02h cb=%b pc=%04h cycle=%0d", name, opcode, cb_prefix, pc, cyc);
      n_vec++;
      if (opcode !== e.op) begin n_err++; $display("FAIL %s opcode: got %02h required %02h", name, opcode, e.op); end
      n_vec++;
      if (cb_prefix !== e.cb) begin n_err++; $display("FAIL %s cb_prefix: got %b required %b", name, cb_prefix, e.cb); end
      n_vec++;
      if (pc !== e.pcv) begin n_err++; $display("FAIL %s pc: got %04h required %04h", name, pc, e.pcv); end
      n_vec++;
      if (cyc !== e.cyc) begin n_err++; $display("FAIL %s latency: got %0d required %0d", name, cyc, e.cyc); end
    end
  endtask

  task automatic test_reset();
    int cyc;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0100) begin
      n_err++; $display("FAIL reset_fetch: mem_rd=%b mem_addr=%04h required 1/0100", mem_rd, mem_addr);
    end
    n_vec++;
    if (op_valid !== 1'b0 || opcode !== 8'h00 || cb_prefix !== 1'b0 || pc !== 16'h0100) begin
      n_err++; $display("FAIL reset_values: valid=%b op=%02h cb=%b pc=%04h required 0/00/0/0100", op_valid, opcode, cb_prefix, pc);
    end
    sb.push_back('{op: 8'h09, cb: 1'b0, pcv: 16'h0101, cyc: 2});
    wait_valid(10, cyc);
    pop_compare("reset_first_op", cyc);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    n_vec++;
    if (op_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0101) begin
      n_err++; $display("FAIL accept_refetch: valid=%b mem_rd=%b addr=%04h required 0/1/0101", op_valid, mem_rd, mem_addr);
    end
  endtask

  task automatic test_cb();
    int cyc;
    op_ready = 1'b1;
    redirect_to(16'h0000);
    sb.push_back('{op: 8'h37, cb: 1'b1, pcv: 16'h0002, cyc: 4});
    wait_valid(10, cyc);
    pop_compare("cb_op", cyc);
    @(negedge clk);
    n_vec++;
    if (op_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0002) begin
      n_err++; $display("FAIL cb_next_fetch: valid=%b mem_rd=%b addr=%04h required 0/1/0002", op_valid, mem_rd, mem_addr);
    end
    op_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    op_ready = 1'b0;
    redirect_to(16'h0300);
    sb.push_back('{op: 8'h3C, cb: 1'b0, pcv: 16'h0301, cyc: 2});
    wait_valid(10, cyc);
    pop_compare("bp_op", cyc);
    for (int i = 0; i < 5; i++) begin
      pc_adv = (i == 0 || i == 2);
      @(negedge clk);
      n_vec++;
      if (op_valid !== 1'b1 || mem_rd !== 1'b0 || opcode !== 8'h3C) begin
        n_err++; $display("FAIL bp_hold%0d: valid=%b mem_rd=%b op=%02h required 1/0/3C", i, op_valid, mem_rd, opcode);
      end
    end
    pc_adv = 1'b0;
    n_vec++;
    if (pc !== 16'h0303) begin n_err++; $display("FAIL bp_pc_adv: pc=%04h required 0303", pc); end
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    n_vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0303) begin
      n_err++; $display("FAIL bp_refetch: mem_rd=%b addr=%04h required 1/0303", mem_rd, mem_addr);
    end
    sb.push_back('{op: 8'h77, cb: 1'b0, pcv: 16'h0304, cyc: 2});
    wait_valid(10, cyc);
    pop_compare("bp_after", cyc);
  endtask

  task automatic test_redirect_cb_wait();
    int cyc;
    op_ready = 1'b0;
    redirect_to(16'h0400);
    repeat (3) @(negedge clk);
    redirect_to(16'hC000);
    n_vec++;
    if (op_valid !== 1'b0 || mem_addr !== 16'hC000 || mem_rd !== 1'b1) begin
      n_err++; $display("FAIL redir_cbwait: valid=%b addr=%04h mem_rd=%b required 0/C000/1", op_valid, mem_addr, mem_rd);
    end
    sb.push_back('{op: 8'h3E, cb: 1'b0, pcv: 16'hC001, cyc: 2});
    wait_valid(10, cyc);
    pop_compare("redir_op", cyc);
  endtask

  task automatic test_wrap();
    int cyc;
    mem[16'h0000] = 8'h11;
    redirect_to(16'hFFFF);
    repeat (2) @(negedge clk);
    n_vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
      n_err++; $display("FAIL wrap_addr: mem_rd=%b addr=%04h required 1/0000", mem_rd, mem_addr);
    end
    sb.push_back('{op: 8'h11, cb: 1'b1, pcv: 16'h0001, cyc: 2});
    wait_valid(10, cyc);
    pop_compare("wrap_op", cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    // Accept and redirect together, while in HOLD
    op_ready = 1'b1;
    redirect_to(16'h0200);
    op_ready = 1'b0;
    n_vec++;
    if (mem_addr !== 16'h0200 || mem_rd !== 1'b1 || op_valid !== 1'b0) begin
      n_err++; $display("FAIL accept_redir: addr=%04h mem_rd=%b valid=%b required 0200/1/0", mem_addr, mem_rd, op_valid);
    end
    sb.push_back('{op: 8'h21, cb: 1'b0, pcv: 16'h0201, cyc: 2});
    wait_valid(10, cyc);
    pop_compare("accept_redir_op", cyc);
    // pc_adv and redirect together
    pc_adv = 1'b1;
    redirect_to(16'h0200);
    pc_adv = 1'b0;
    n_vec++;
    if (mem_addr !== 16'h0200 || pc !== 16'h0200) begin
      n_err++; $display("FAIL adv_redir: addr=%04h pc=%04h required 0200/0200", mem_addr, pc);
    end
    sb.push_back('{op: 8'h21, cb: 1'b0, pcv: 16'h0201, cyc: 2});
    wait_valid(10, cyc);
    pop_compare("adv_redir_op", cyc);
    // Throughput: always ready, plain opcodes every 3 cycles
    op_ready = 1'b1;
    redirect_to(16'h0500);
    for (int i = 0; i < 3; i++)
      sb.push_back('{op: 8'(8'h01 + i), cb: 1'b0, pcv: 16'(16'h0501 + i), cyc: 2 + 3 * i});
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      if (op_valid === 1'b1) pop_compare("stream", cyc);
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (sb.size() != 0) begin n_err++; $display("FAIL stream_drain: %0d left, required 0", sb.size()); sb.delete(); end
    op_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    op_ready = 1'b0;
    redirect_to(16'h0400);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0100 || pc !== 16'h0100 || op_valid !== 1'b0 ||
        opcode !== 8'h00 || cb_prefix !== 1'b0) begin
      n_err++; $display("FAIL reset_mid: rd=%b addr=%04h pc=%04h valid=%b op=%02h cb=%b required 1/0100/0100/0/00/0",
                        mem_rd, mem_addr, pc, op_valid, opcode, cb_prefix);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'h09;
    mem[16'h0000] = 8'hCB; mem[16'h0001] = 8'h37; mem[16'h0002] = 8'h05;
    mem[16'h0300] = 8'h3C; mem[16'h0303] = 8'h77;
    mem[16'h0400] = 8'hCB; mem[16'h0401] = 8'h12;
    mem[16'hC000] = 8'h3E;
    mem[16'hFFFF] = 8'hCB;
    mem[16'h0200] = 8'h21;
    mem[16'h0500] = 8'h01; mem[16'h0501] = 8'h02; mem[16'h0502] = 8'h03;
    reset = 1'b1; op_ready = 1'b0; pc_adv = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    test_reset();
    test_cb();
    test_backpressure();
    test_redirect_cb_wait();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
